// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the 6502 program counter stage: sequencer state
// encoding, default reset-vector addresses and datapath widths.
// -----------------------------------------------------------------------------
package pc_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  localparam logic [WORD_W-1:0] VEC_LO_DEF = 16'hFFFC;
  localparam logic [WORD_W-1:0] VEC_HI_DEF = 16'hFFFD;

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    RUN    = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_incrementer.sv
// -----------------------------------------------------------------------------
// pc_incrementer
// One byte slice of the program counter increment chain, purely combinational.
// Ports:
//   a    - byte to increment
//   cin  - carry in (increment request or carry from the lower byte)
//   sum  - a + cin, modulo 256
//   cout - carry out into the next byte
// -----------------------------------------------------------------------------
module pc_incrementer
  import pc_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  assign {cout, sum} = {1'b0, a} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program counter stage of the 6502 datapath: PCL/PCH source select, the
// increment chain and the PCL/PCH register pair. Drives ADL/ADH and DB.
//
// Build option: define PC_VECTOR_FETCH_EN to include the reset-vector fetch
// sequencer (VEC_LO -> VEC_HI -> RUN). Without it the block resets directly
// into RUN with PC = 0000, VEC_BUSY stays 0 and DB_DATA is ignored.
//
// Ports:
//   CLK, RST_N            - clock, asynchronous active-low reset
//   ADL_LOAD, ADH_LOAD    - take PCL/PCH from ADL_DATA/ADH_DATA instead of hold
//   I_PC                  - add one to the selected 16-bit value
//   ADL_DATA, ADH_DATA    - jump/branch target bytes
//   DB_DATA               - data bus input, read only by the vector fetch
//   PCL_DB_EN, PCH_DB_EN  - drive PCL / PCH on DB_OUT (PCL has priority)
//   PCL_ADL_EN, PCH_ADH_EN- drive PCL on ADL_OUT / PCH on ADH_OUT
//   DB_OUT, ADL_OUT, ADH_OUT - bus drives, 00 when not enabled
//   PC                    - {PCH, PCL} for trace
//   VEC_BUSY              - high while the vector fetch is running
// -----------------------------------------------------------------------------
module pc_unit
  import pc_pkg::*;
#(
  parameter logic [WORD_W-1:0] VEC_LO = VEC_LO_DEF,
  parameter logic [WORD_W-1:0] VEC_HI = VEC_HI_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ADL_LOAD,
  input  logic              ADH_LOAD,
  input  logic              I_PC,
  input  logic [BYTE_W-1:0] ADL_DATA,
  input  logic [BYTE_W-1:0] ADH_DATA,
  input  logic [BYTE_W-1:0] DB_DATA,
  input  logic              PCL_DB_EN,
  input  logic              PCH_DB_EN,
  input  logic              PCL_ADL_EN,
  input  logic              PCH_ADH_EN,
  output logic [BYTE_W-1:0] DB_OUT,
  output logic [BYTE_W-1:0] ADL_OUT,
  output logic [BYTE_W-1:0] ADH_OUT,
  output logic [WORD_W-1:0] PC,
  output logic              VEC_BUSY
);

  logic [BYTE_W-1:0] pcl_q, pcl_d;
  logic [BYTE_W-1:0] pch_q, pch_d;
  logic [BYTE_W-1:0] pcls_s, pchs_s;
  logic [BYTE_W-1:0] pcl_inc_s, pch_inc_s;
  logic              pcl_cout_s;
  logic              pch_cout_unused_s;
  logic              vlo_s, vhi_s, run_s;

`ifdef PC_VECTOR_FETCH_EN
  pc_state_t state_q, state_d;

  // Sequencer next state: two fetch cycles, then RUN until the next reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      pc_pkg::VEC_LO: state_d = pc_pkg::VEC_HI;
      pc_pkg::VEC_HI: state_d = pc_pkg::RUN;
      pc_pkg::RUN:    state_d = pc_pkg::RUN;
      // An illegal encoding restarts the fetch so the PC is rebuilt from the vector.
      default:        state_d = pc_pkg::VEC_LO;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= pc_pkg::VEC_LO;
    end else begin
      state_q <= state_d;
    end
  end

  assign vlo_s = (state_q == pc_pkg::VEC_LO);
  assign vhi_s = (state_q == pc_pkg::VEC_HI);
  assign run_s = (state_q == pc_pkg::RUN);
`else
  assign vlo_s = 1'b0;
  assign vhi_s = 1'b0;
  assign run_s = 1'b1;
`endif

  assign pcls_s = ADL_LOAD ? ADL_DATA : pcl_q;
  assign pchs_s = ADH_LOAD ? ADH_DATA : pch_q;

  pc_incrementer u_inc_lo (
    .a    (pcls_s),
    .cin  (I_PC),
    .sum  (pcl_inc_s),
    .cout (pcl_cout_s)
  );

  // The high byte sees the low-byte carry in the same cycle; its own carry
  // is dropped so FFFF + 1 wraps to 0000.
  pc_incrementer u_inc_hi (
    .a    (pchs_s),
    .cin  (pcl_cout_s),
    .sum  (pch_inc_s),
    .cout (pch_cout_unused_s)
  );

  // PC next value: vector bytes during the fetch, select + increment in RUN.
  always_comb begin
    pcl_d = pcl_q;
    pch_d = pch_q;
    if (vlo_s) begin
      pcl_d = DB_DATA;
    end else if (vhi_s) begin
      pch_d = DB_DATA;
    end else if (run_s) begin
      pcl_d = pcl_inc_s;
      pch_d = pch_inc_s;
    end else begin
      pcl_d = pcl_q;
      pch_d = pch_q;
    end
  end

  // PCL/PCH register pair.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pcl_q <= 8'h00;
      pch_q <= 8'h00;
    end else begin
      pcl_q <= pcl_d;
      pch_q <= pch_d;
    end
  end

  // Bus drives: gated by RST_N so the forced vector address never leaks out
  // while reset is held, even though the sequencer already sits in VEC_LO.
  always_comb begin
    DB_OUT  = 8'h00;
    ADL_OUT = 8'h00;
    ADH_OUT = 8'h00;
    if (!RST_N) begin
      DB_OUT  = 8'h00;
      ADL_OUT = 8'h00;
      ADH_OUT = 8'h00;
    end else if (vlo_s) begin
      ADL_OUT = VEC_LO[7:0];
      ADH_OUT = VEC_LO[15:8];
    end else if (vhi_s) begin
      ADL_OUT = VEC_HI[7:0];
      ADH_OUT = VEC_HI[15:8];
    end else begin
      if (PCL_DB_EN) begin
        DB_OUT = pcl_q;
      end else if (PCH_DB_EN) begin
        DB_OUT = pch_q;
      end else begin
        DB_OUT = 8'h00;
      end
      ADL_OUT = PCL_ADL_EN ? pcl_q : 8'h00;
      ADH_OUT = PCH_ADH_EN ? pch_q : 8'h00;
    end
  end

  assign VEC_BUSY = RST_N & (vlo_s | vhi_s);
  assign PC       = {pch_q, pcl_q};

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
// Self-checking bench for pc_unit: directed cases followed by randomized
// controls, compared against a 16-bit arithmetic reference model.
// Works with or without PC_VECTOR_FETCH_EN.
// -----------------------------------------------------------------------------
module tb_pc_unit;

  logic       CLK;
  logic       RST_N;
  logic       ADL_LOAD, ADH_LOAD, I_PC;
  logic [7:0] ADL_DATA, ADH_DATA, DB_DATA;
  logic       PCL_DB_EN, PCH_DB_EN, PCL_ADL_EN, PCH_ADH_EN;
  logic [7:0] DB_OUT, ADL_OUT, ADH_OUT;
  logic [15:0] PC;
  logic       VEC_BUSY;

  int total;
  int bad;

  // Reference model: the PC as a plain 16-bit number plus a fetch phase
  // (0 = low vector byte, 1 = high vector byte, 2 = running).
  logic [15:0] m_pc;
  int          m_phase;

  pc_unit dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ADL_LOAD   (ADL_LOAD),
    .ADH_LOAD   (ADH_LOAD),
    .I_PC       (I_PC),
    .ADL_DATA   (ADL_DATA),
    .ADH_DATA   (ADH_DATA),
    .DB_DATA    (DB_DATA),
    .PCL_DB_EN  (PCL_DB_EN),
    .PCH_DB_EN  (PCH_DB_EN),
    .PCL_ADL_EN (PCL_ADL_EN),
    .PCH_ADH_EN (PCH_ADH_EN),
    .DB_OUT     (DB_OUT),
    .ADL_OUT    (ADL_OUT),
    .ADH_OUT    (ADH_OUT),
    .PC         (PC),
    .VEC_BUSY   (VEC_BUSY)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000;
`ifdef PC_VECTOR_FETCH_EN
    m_phase = 0;
`else
    m_phase = 2;
`endif
  endtask

  // Advance the model by one rising edge using the inputs that were sampled.
  task automatic model_edge();
    logic [7:0] lo;
    logic [7:0] hi;
    if (!RST_N) begin
      model_reset();
    end else if (m_phase == 0) begin
      m_pc[7:0] = DB_DATA;
      m_phase   = 1;
    end else if (m_phase == 1) begin
      m_pc[15:8] = DB_DATA;
      m_phase    = 2;
    end else begin
      lo   = ADL_LOAD ? ADL_DATA : m_pc[7:0];
      hi   = ADH_LOAD ? ADH_DATA : m_pc[15:8];
      m_pc = {hi, lo} + {15'd0, I_PC};
    end
  endtask

  task automatic check_outputs();
    logic [7:0] e_db, e_adl, e_adh;
    logic       e_busy;
    e_db = 8'h00; e_adl = 8'h00; e_adh = 8'h00; e_busy = 1'b0;
    if (RST_N && m_phase == 0) begin
      {e_adh, e_adl} = 16'hFFFC;
      e_busy = 1'b1;
    end else if (RST_N && m_phase == 1) begin
      {e_adh, e_adl} = 16'hFFFD;
      e_busy = 1'b1;
    end else if (RST_N) begin
      e_db  = PCL_DB_EN ? m_pc[7:0] : (PCH_DB_EN ? m_pc[15:8] : 8'h00);
      e_adl = PCL_ADL_EN ? m_pc[7:0] : 8'h00;
      e_adh = PCH_ADH_EN ? m_pc[15:8] : 8'h00;
    end
    check_eq("pc", PC, m_pc);
    check_eq("db_out", {8'h00, DB_OUT}, {8'h00, e_db});
    check_eq("adl_out", {8'h00, ADL_OUT}, {8'h00, e_adl});
    check_eq("adh_out", {8'h00, ADH_OUT}, {8'h00, e_adh});
    check_eq("vec_busy", {15'd0, VEC_BUSY}, {15'd0, e_busy});
  endtask

  // Called just after a rising edge: check, take one edge, update the model.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic set_ctl(input logic al, input logic ah, input logic ipc,
                         input logic [7:0] adl, input logic [7:0] adh,
                         input logic [7:0] db, input logic [3:0] en);
    ADL_LOAD = al; ADH_LOAD = ah; I_PC = ipc;
    ADL_DATA = adl; ADH_DATA = adh; DB_DATA = db;
    {PCL_DB_EN, PCH_DB_EN, PCL_ADL_EN, PCH_ADH_EN} = en;
  endtask

  // Hold reset across one edge, release between edges.
  task automatic do_reset();
    RST_N = 1'b0;
    model_reset();
    #1;
    check_eq("rst_pc", PC, 16'h0000);
    check_eq("rst_busy", {15'd0, VEC_BUSY}, 16'h0000);
    cycle();
    RST_N = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST_N = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 4'b1111);
    model_reset();
    #1;
    check_eq("rst_adl", {8'h00, ADL_OUT}, 16'h0000);
    check_eq("rst_db", {8'h00, DB_OUT}, 16'h0000);
    do_reset();
    set_ctl(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h34, 4'b0000);

`ifdef PC_VECTOR_FETCH_EN
    #1;
    check_eq("vec_lo_addr", {ADH_OUT, ADL_OUT}, 16'hFFFC);
    check_eq("vec_lo_busy", {15'd0, VEC_BUSY}, 16'h0001);
    cycle();
    check_eq("vec_hi_addr", {ADH_OUT, ADL_OUT}, 16'hFFFD);
    DB_DATA = 8'h12;
    cycle();
    check_eq("vec_pc", PC, 16'h1234);
    check_eq("vec_done_busy", {15'd0, VEC_BUSY}, 16'h0000);

    // Reset in the middle of the fetch, then a full restart.
    do_reset();
    DB_DATA = 8'h77;
    cycle();
    RST_N = 1'b0;
    model_reset();
    #1;
    check_eq("midfetch_pc", PC, 16'h0000);
    check_eq("midfetch_busy", {15'd0, VEC_BUSY}, 16'h0000);
    cycle();
    RST_N = 1'b1;
    #1;
    check_eq("refetch_addr", {ADH_OUT, ADL_OUT}, 16'hFFFC);
    DB_DATA = 8'h34;
    cycle();
    DB_DATA = 8'h12;
    cycle();
    check_eq("refetch_pc", PC, 16'h1234);
`else
    check_eq("nofetch_busy", {15'd0, VEC_BUSY}, 16'h0000);
    I_PC = 1'b1;
    cycle();
    cycle();
    cycle();
    check_eq("inc3_pc", PC, 16'h0003);
`endif

    // Page carry and wrap.
    set_ctl(1'b1, 1'b1, 1'b0, 8'hFF, 8'h12, 8'h00, 4'b0000);
    cycle();
    check_eq("jmp_12ff", PC, 16'h12FF);
    set_ctl(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 4'b0000);
    cycle();
    check_eq("carry_1300", PC, 16'h1300);
    set_ctl(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 4'b0000);
    cycle();
    set_ctl(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 4'b0000);
    cycle();
    check_eq("wrap_0000", PC, 16'h0000);

    // Jump with and without increment.
    set_ctl(1'b1, 1'b1, 1'b1, 8'hCD, 8'hAB, 8'h00, 4'b0000);
    cycle();
    check_eq("jmp_inc", PC, 16'hABCE);
    I_PC = 1'b0;
    cycle();
    check_eq("jmp_noinc", PC, 16'hABCD);

    // Bus drive at PC = ABCD.
    set_ctl(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 4'b0011);
    #1;
    check_eq("adl_adh_drive", {ADH_OUT, ADL_OUT}, 16'hABCD);
    {PCL_DB_EN, PCH_DB_EN, PCL_ADL_EN, PCH_ADH_EN} = 4'b1100;
    #1;
    check_eq("db_pcl_wins", {8'h00, DB_OUT}, 16'h00CD);
    {PCL_DB_EN, PCH_DB_EN, PCL_ADL_EN, PCH_ADH_EN} = 4'b0000;
    #1;
    check_eq("all_off", {DB_OUT, ADL_OUT}, 16'h0000);
    check_eq("all_off_adh", {8'h00, ADH_OUT}, 16'h0000);
    cycle();

    // Randomized controls with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) begin
        do_reset();
      end
      set_ctl($urandom_range(3) == 0, $urandom_range(3) == 0, 1'($urandom_range(1)),
              8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
      cycle();
    end
    #1;
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program counter stage for the 6502 datapath. It merges the program counter select logic, the increment logic and the 16-bit PCL/PCH register pair into one clocked block. It feeds the address bus drivers (ADL/ADH) and the internal data bus (DB), and it takes jump and branch targets back from ADL/ADH. An optional sequencer fetches the reset vector after reset.

## Interface
Parameters:
- VEC_LO, 16'hFFFC, address of the reset-vector low byte
- VEC_HI, 16'hFFFD, address of the reset-vector high byte

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RST_N  in  1  reset; asynchronous, active-low
- ADL_LOAD  in  1  select ADL_DATA as the PCL source (PCLS), else hold PCL
- ADH_LOAD  in  1  select ADH_DATA as the PCH source (PCHS), else hold PCH
- I_PC  in  1  add 1 to the selected 16-bit value
- ADL_DATA  in  8  jump/branch low byte
- ADH_DATA  in  8  jump/branch high byte
- DB_DATA  in  8  data bus input, used only by the vector fetch
- PCL_DB_EN, PCH_DB_EN  in  1  drive PCL / PCH onto DB_OUT
- PCL_ADL_EN, PCH_ADH_EN  in  1  drive PCL onto ADL_OUT / PCH onto ADH_OUT
- DB_OUT  out  8  data bus drive
- ADL_OUT, ADH_OUT  out  8  address bus low / high drive
- PC  out  16  {PCH, PCL}, for debug and trace
- VEC_BUSY  out  1  high while the vector fetch is in progress

## Operation
- Select: PCLS = ADL_LOAD ? ADL_DATA : PCL; PCHS = ADH_LOAD ? ADH_DATA : PCH.
- Increment, in RUN only:
  - {PCH, PCL} <= {PCHS, PCLS} + I_PC.
  - The carry out of PCL goes into PCH in the same cycle.
  - 16'hFFFF + 1 wraps to 16'h0000.
- No load and no increment means PC holds.
- Output enables:
  - DB_OUT = PCL if PCL_DB_EN; else PCH if PCH_DB_EN; else 8'h00. If both enables are set, PCL wins.
  - ADL_OUT = PCL_ADL_EN ? PCL : 8'h00.
  - ADH_OUT = PCH_ADH_EN ? PCH : 8'h00.
- State machine, with PC_VECTOR_FETCH_EN defined:
  - VEC_LO:
    - ADL_OUT/ADH_OUT force VEC_LO and VEC_BUSY=1.
    - All controls and enables are ignored; DB_OUT=00.
    - On the edge, PCL <= DB_DATA; go to VEC_HI.
  - VEC_HI: as VEC_LO but with VEC_HI forced on the address outputs. On the edge, PCH <= DB_DATA; go to RUN.
  - RUN: normal operation; terminal state until reset.
- Reset (asserted at any time, including mid-fetch or mid-increment):
  - PC=16'h0000; DB_OUT, ADL_OUT, ADH_OUT = 8'h00; VEC_BUSY=0.
  - State is VEC_LO if the fetch is compiled in, else RUN.
  - Outputs show the reset state combinationally while RST_N=0.

## Timing
- Address and data outputs are combinational from registers and enables, so an enable takes effect in the same cycle.
- Load/increment latency: 1 cycle. The new PC is visible after the edge where the control was sampled.
- Vector fetch: the first rising edge with RST_N=1 captures the low byte and the second captures the high byte. The PC holding the vector is valid and VEC_BUSY=0 from the cycle after the second edge.
- Reset release between edges: the fetch starts at the next edge; no recovery check inside the block.

## Configuration
- PC_VECTOR_FETCH_EN defined: the VEC_LO → VEC_HI → RUN sequencer is present, and VEC_BUSY behaves as described in Operation.
- PC_VECTOR_FETCH_EN undefined: no sequencer; the block resets straight into RUN with PC=0000. VEC_BUSY is tied to 0 and DB_DATA is unused.

## Structure
- Shared package pc_pkg holds:
  - pc_state_t enum {VEC_LO, VEC_HI, RUN}
  - default vector constants 16'hFFFC / 16'hFFFD
  - 8-bit and 16-bit width constants
- Sub-module pc_incrementer: 8-bit value + carry-in → 8-bit sum + carry-out, combinational. It is instantiated twice: for PCL with cin=I_PC, and for PCH with cin=PCL carry-out.

## Test plan
- Reset, then fetch (macro on):
  - RST_N low → PC=0000, outputs 00.
  - Release; DB_DATA=34 in the first cycle and 12 in the second → ADL/ADH show FC/FF then FD/FF; VEC_BUSY=1 for two cycles; then PC=1234 and VEC_BUSY=0.
- Page carry: PC=12FF, I_PC=1 → PC=1300 after one edge. PC=FFFF, I_PC=1 → PC=0000.
- Jump with increment: ADL_LOAD=ADH_LOAD=1, ADL_DATA=CD, ADH_DATA=AB, I_PC=1 → PC=ABCE. The same controls with I_PC=0 → PC=ABCD.
- Bus drive: PC=ABCD.
  - PCL_ADL_EN=PCH_ADH_EN=1 → ADL_OUT=CD, ADH_OUT=AB.
  - PCL_DB_EN=PCH_DB_EN=1 → DB_OUT=CD.
  - All enables off → all outputs 00.
- Reset mid-fetch: assert RST_N after the VEC_LO edge → PC=0000 immediately; the fetch restarts at VEC_LO on release.
- Macro off: after reset PC=0000 and VEC_BUSY=0; I_PC=1 for 3 cycles → PC=0003.
